// File: rtl/ir_nec_encode_if.sv
// Request/acknowledge bundle between a frame source and the NEC transmitter.
// The source drives the word and the two request strobes; the transmitter answers with ready and done.
interface ir_nec_encode_if;
    logic [31:0] tx_data;
    logic        tx_vld;
    logic        rpt_vld;
    logic        tx_rdy;
    logic        tx_done;

    modport master (
        output tx_data,
        output tx_vld,
        output rpt_vld,
        input  tx_rdy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_vld,
        input  rpt_vld,
        output tx_rdy,
        output tx_done
    );
endinterface

// File: rtl/ir_nec_encode.sv
// NEC infrared transmitter: serialises a 32-bit word (LSB first) or a repeat code into a
// mark/space envelope, optionally modulated onto a 38kHz carrier for the IR LED.
module ir_nec_encode #(
    parameter logic [21:0] T_LEAD_MARK  = 22'd450_000,
    parameter logic [21:0] T_LEAD_SPACE = 22'd225_000,
    parameter logic [21:0] T_RPT_SPACE  = 22'd112_500,
    parameter logic [21:0] T_BIT_MARK   = 22'd28_000,
    parameter logic [21:0] T_ZERO_SPACE = 22'd28_000,
    parameter logic [21:0] T_ONE_SPACE  = 22'd84_500,
    parameter logic [21:0] T_GAP        = 22'd2_000_000,
    parameter logic [10:0] CARRIER_HALF = 11'd658,
    parameter bit          CARRIER_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ir_nec_encode_if.slave     bus,
    output logic               ir_mark,
    output logic               ir_tx
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        RPT_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [21:0] cnt;
    logic [21:0] seg_len;
    logic        seg_end;
    logic [31:0] shreg;
    logic [4:0]  bit_idx;
    logic        is_rpt;
    logic [10:0] car_cnt;
    logic        carrier;
    logic        accept_data;
    logic        accept_rpt;
    logic        mark_now;
    logic        mark_nx;

    // A data request outranks a simultaneous repeat request; the repeat is simply dropped.
    assign accept_data = (state == IDLE) && bus.tx_rdy && bus.tx_vld;
    assign accept_rpt  = (state == IDLE) && bus.tx_rdy && !bus.tx_vld && bus.rpt_vld;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        seg_len = T_GAP;
        case (state)
            LEAD_MARK:            seg_len = T_LEAD_MARK;
            LEAD_SPACE:           seg_len = T_LEAD_SPACE;
            RPT_SPACE:            seg_len = T_RPT_SPACE;
            BIT_MARK, STOP_MARK:  seg_len = T_BIT_MARK;
            BIT_SPACE:            seg_len = shreg[0] ? T_ONE_SPACE : T_ZERO_SPACE;
            default:              seg_len = T_GAP;
        endcase
    end

    assign seg_end = (cnt == seg_len - 22'd1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (accept_data || accept_rpt) state_nx = LEAD_MARK;
            LEAD_MARK:  if (seg_end) state_nx = is_rpt ? RPT_SPACE : LEAD_SPACE;
            LEAD_SPACE: if (seg_end) state_nx = BIT_MARK;
            RPT_SPACE:  if (seg_end) state_nx = STOP_MARK;
            BIT_MARK:   if (seg_end) state_nx = BIT_SPACE;
            BIT_SPACE:  if (seg_end) state_nx = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (seg_end) state_nx = GAP;
            GAP:        if (seg_end) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    assign mark_now = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    assign mark_nx  = (state_nx == LEAD_MARK) || (state_nx == BIT_MARK) || (state_nx == STOP_MARK);

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            is_rpt      <= 1'b0;
            ir_mark     <= 1'b0;
            bus.tx_rdy  <= 1'b0;
            bus.tx_done <= 1'b0;
            car_cnt     <= '0;
            carrier     <= 1'b0;
        end else begin
            cnt         <= (state_nx != state) ? 22'd0 : cnt + 22'd1;
            ir_mark     <= mark_nx;
            bus.tx_rdy  <= (state_nx == IDLE);
            bus.tx_done <= (state == STOP_MARK) && seg_end;

            if (accept_data) begin
                shreg  <= bus.tx_data;
                is_rpt <= 1'b0;
            end else if (accept_rpt) begin
                is_rpt <= 1'b1;
            end

            if ((state == LEAD_SPACE) && seg_end) bit_idx <= '0;
            if ((state == BIT_SPACE) && seg_end) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 5'd1;
            end

            // Restart the carrier at every burst so each mark begins with a full high half-period.
            if (mark_nx && !mark_now) begin
                car_cnt <= '0;
                carrier <= 1'b1;
            end else if (car_cnt == CARRIER_HALF - 11'd1) begin
                car_cnt <= '0;
                carrier <= ~carrier;
            end else begin
                car_cnt <= car_cnt + 11'd1;
            end
        end
    end

    assign ir_tx = CARRIER_EN ? (ir_mark & carrier) : ir_mark;

endmodule
